tx_arbiter64: RTL
=================

Name: tx_arbiter64

Overview:
- Arbitrates the transmit side of the 64-bit UART transceiver between NREQ independent requesters.
- Each requester presents a 64-bit word.
- The arbiter grants round-robin and drives a single-cycle tx_wr with the latched word. It then waits for the transceiver's tx_done.
- On a lost acknowledge (timeout) it re-issues the same word a bounded number of times.
- Sits between the packet-producing logic and transceiver64's tx_wr/tx_data/tx_done ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 4096, cycles to wait for tx_done after a tx_wr before retrying.
- MAX_RETRY, 3, re-issues allowed after the first attempt before failing.
- CNT_W, 16, timeout counter width; must hold TIMEOUT-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level; held until ack or nack.
- req_data  input  64*NREQ  word for requester i on bits [64*i+63:64*i]; stable while req[i]=1.
- grant  output  NREQ  one-hot; high for the active requester during ISSUE and WAIT.
- ack  output  NREQ  one-cycle pulse: word delivered (tx_done seen).
- nack  output  NREQ  one-cycle pulse: word abandoned after MAX_RETRY retries.
- busy  output  1  high in any state except IDLE.
- tx_wr  output  1  one-cycle write strobe to transceiver.
- tx_data  output  64  latched word to transceiver.
- tx_done  input  1  transceiver completion, sampled level/pulse.
- retry_cnt  output  2..  retries used on the current word, width clog2(MAX_RETRY+1).

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state, including mid-transfer): state=IDLE; grant, ack, nack, tx_wr, busy, retry_cnt, timer, tx_data all 0; last_grant=NREQ-1 so requester 0 has first priority. An in-flight word is dropped with no ack or nack.
- IDLE:
  - If req != 0, select the first set bit searching from last_grant+1 upward, wrapping modulo NREQ.
  - Latch req_data of the winner into tx_data and set grant one-hot.
  - Clear retry_cnt and go to ISSUE.
  - Selection latency: req sampled at edge t, grant/tx_data valid after edge t.
- ISSUE (exactly 1 cycle): tx_wr=1, timer cleared; go to WAIT. tx_wr is high only in ISSUE.
- WAIT: timer increments each cycle.
  - tx_done=1: pulse ack[cur] next cycle, drop grant, set last_grant=cur, go to IDLE.
  - Else if timer==TIMEOUT-1 and retry_cnt<MAX_RETRY: retry_cnt+1, go to ISSUE. tx_data is unchanged, so the same word is re-sent.
  - Else if timer==TIMEOUT-1 and retry_cnt==MAX_RETRY: pulse nack[cur], drop grant, set last_grant=cur, go to IDLE.
  - tx_done and timeout in the same cycle: tx_done wins (ack, no retry).
- tx_done while in IDLE or ISSUE is ignored.
- Requester dropping req mid-transaction: ignored; the transfer completes and ack/nack still pulses.
- After ack/nack the arbiter spends at least one cycle in IDLE. A requester still asserting req on the ack cycle is re-arbitrated with its priority now lowest.
- Throughput bound: the minimum gap from one tx_wr to the next is 3 cycles (ISSUE, WAIT with tx_done, IDLE).
- ack and nack are mutually exclusive and at most one bit of either is high.

Test Plan:
- Reset, then req=0001 with word 64'haabbccdd11223344 → tx_wr pulse 1 cycle with tx_data=64'haabbccdd11223344. Model tx_done 10 cycles later → ack=0001 one cycle, busy falls, retry_cnt=0.
- req=1111 held, each with distinct data, tx_done returned 5 cycles after every tx_wr → grant order 0001, 0010, 0100, 1000, 0001; each ack matches; no requester starves.
- TIMEOUT=16, MAX_RETRY=3, tx_done never asserted → 4 tx_wr pulses 17 cycles apart, all with identical tx_data; retry_cnt 0→3; then nack for that requester; no ack.
- tx_done asserted exactly on the timeout cycle → ack, no extra tx_wr, retry_cnt unchanged.
- Reset asserted during WAIT with grant=0100 → all outputs 0 immediately (asynchronous); after release, req=0100 still held is re-served starting from requester 0 priority.
- Loopback through transceiver64 (UART_TX to UART_RX, RECEIVED_TX to RECEIVED_RX), requesters 0 and 2 both sending → rx_data sequence equals the sent words in grant order; two acks, zero nacks.

Source files
------------

// File: rtl/tx_arbiter64.sv
// tx_arbiter64: round-robin arbiter that hands 64-bit words from NREQ
// requesters to the transceiver. It retries each word on a lost acknowledge
// and gives up after MAX_RETRY re-issues.
module tx_arbiter64 #(
  parameter int NREQ      = 4,
  parameter int TIMEOUT   = 4096,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NREQ-1:0]                    req,
  input  logic [64*NREQ-1:0]                 req_data,
  output logic [NREQ-1:0]                    grant,
  output logic [NREQ-1:0]                    ack,
  output logic [NREQ-1:0]                    nack,
  output logic                               busy,
  output logic                               tx_wr,
  output logic [63:0]                        tx_data,
  input  logic                               tx_done,
  output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int RW    = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state, next_state;

  logic [IDX_W-1:0] cur, cur_d;
  logic [IDX_W-1:0] last_grant, last_grant_d;
  logic [CNT_W-1:0] timer, timer_d;
  logic [NREQ-1:0]  grant_d, ack_d, nack_d;
  logic             busy_d, tx_wr_d;
  logic [63:0]      tx_data_d;
  logic [RW-1:0]    retry_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             timed_out;

  assign timed_out = (timer == CNT_W'(TIMEOUT - 1));

  // Rotating priority search: the requester just after last_grant goes first.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register; reset abandons any in-flight word silently.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next state: one ISSUE cycle per write, then wait for done or timeout.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (win_found) next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT: begin
        if (tx_done)                                next_state = S_IDLE;
        else if (timed_out && retry_cnt < RW'(MAX_RETRY)) next_state = S_ISSUE;
        else if (timed_out)                         next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath; tx_done beats timeout.
  always_comb begin
    cur_d        = cur;
    last_grant_d = last_grant;
    timer_d      = timer;
    grant_d      = grant;
    ack_d        = '0;
    nack_d       = '0;
    tx_data_d    = tx_data;
    retry_d      = retry_cnt;
    tx_wr_d      = 1'b0;
    busy_d       = (next_state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (win_found) begin
          cur_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          tx_data_d        = req_data[64*win_idx +: 64];
          retry_d          = '0;
          timer_d          = '0;
          tx_wr_d          = 1'b1;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
      end
      S_WAIT: begin
        if (tx_done) begin
          ack_d[cur]   = 1'b1;
          grant_d      = '0;
          last_grant_d = cur;
        end else if (timed_out && retry_cnt < RW'(MAX_RETRY)) begin
          retry_d = retry_cnt + RW'(1);
          timer_d = '0;
          tx_wr_d = 1'b1;
        end else if (timed_out) begin
          nack_d[cur]  = 1'b1;
          grant_d      = '0;
          last_grant_d = cur;
        end else begin
          timer_d = timer + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers; last_grant resets so requester 0 wins first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur        <= '0;
      last_grant <= IDX_W'(NREQ - 1);
      timer      <= '0;
      grant      <= '0;
      ack        <= '0;
      nack       <= '0;
      busy       <= 1'b0;
      tx_wr      <= 1'b0;
      tx_data    <= '0;
      retry_cnt  <= '0;
    end else begin
      cur        <= cur_d;
      last_grant <= last_grant_d;
      timer      <= timer_d;
      grant      <= grant_d;
      ack        <= ack_d;
      nack       <= nack_d;
      busy       <= busy_d;
      tx_wr      <= tx_wr_d;
      tx_data    <= tx_data_d;
      retry_cnt  <= retry_d;
    end
  end

endmodule
